// File: rtl/tinyml_cmd_initiator_pkg.sv
// Shared tinyml constants: initiator FSM encoding, datapath widths and timeout counter width.
package tinyml_cmd_initiator_pkg;

  localparam int FUNC_ID_W = 10;
  localparam int DATA_W    = 32;
  localparam int TMO_CNT_W = 16;

  typedef logic [FUNC_ID_W-1:0] func_id_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [TMO_CNT_W-1:0] tmo_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tinyml_cmd_initiator.sv
// Host-side initiator for the tinyml custom-instruction port: issues one command at a time,
// waits for its response (bounded by TIMEOUT_CYCLES) and hands the result back to the host.
module tinyml_cmd_initiator
  import tinyml_cmd_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_function_id,
  input  logic [31:0] req_inputs_0,
  input  logic [31:0] req_inputs_1,

  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_timeout,

  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_function_id,
  output logic [31:0] cmd_inputs_0,
  output logic [31:0] cmd_inputs_1,

  input  logic        rsp_valid,
  input  logic [31:0] rsp_outputs_0,
  output logic        rsp_ready,

  input  logic        cmd_int,
  output logic        int_pending,
  input  logic        int_clear,

  output logic        busy
);

  localparam tmo_cnt_t TMO_LAST = tmo_cnt_t'(TIMEOUT_CYCLES - 1);

  state_t   state;
  tmo_cnt_t tmo_cnt;

  // NOTE: every register here is state, so all assignments are non-blocking; using '=' would
  // let later statements in the block see this cycle's update and break the registered timing.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      tmo_cnt         <= '0;
      req_ready       <= 1'b0;
      cmd_valid       <= 1'b0;
      rsp_ready       <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      res_timeout     <= 1'b0;
      cmd_function_id <= '0;
      cmd_inputs_0    <= '0;
      cmd_inputs_1    <= '0;
      int_pending     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      // A new interrupt outranks a clear arriving in the same cycle.
      if (cmd_int) begin
        int_pending <= 1'b1;
      end else if (int_clear) begin
        int_pending <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            cmd_function_id <= req_function_id;
            cmd_inputs_0    <= req_inputs_0;
            cmd_inputs_1    <= req_inputs_1;
            req_ready       <= 1'b0;
            cmd_valid       <= 1'b1;
            rsp_ready       <= 1'b1;
            busy            <= 1'b1;
            state           <= ST_CMD;
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_CMD: begin
          // A response is only meaningful once the command has been taken.
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (rsp_valid) begin
              res_data    <= rsp_outputs_0;
              res_timeout <= 1'b0;
              rsp_ready   <= 1'b0;
              res_valid   <= 1'b1;
              state       <= ST_DONE;
            end else begin
              tmo_cnt <= '0;
              state   <= ST_RSP;
            end
          end
        end

        ST_RSP: begin
          if (rsp_valid) begin
            res_data    <= rsp_outputs_0;
            res_timeout <= 1'b0;
            rsp_ready   <= 1'b0;
            res_valid   <= 1'b1;
            state       <= ST_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            res_data    <= '0;
            res_timeout <= 1'b1;
            rsp_ready   <= 1'b0;
            res_valid   <= 1'b1;
            state       <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + tmo_cnt_t'(1);
          end
        end

        ST_DONE: begin
          // req_ready rises with the return to IDLE, so the next accept is one cycle later.
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyml_cmd_initiator.sv
// Self-checking bench for tinyml_cmd_initiator: directed vector table, hand-written reset and
// interrupt sequences, and randomized transactions scored against a transaction-level model.
module tb_tinyml_cmd_initiator;

  localparam int T = 8;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_function_id;
  logic [31:0] req_inputs_0;
  logic [31:0] req_inputs_1;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_timeout;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_function_id;
  logic [31:0] cmd_inputs_0;
  logic [31:0] cmd_inputs_1;
  logic        rsp_valid;
  logic [31:0] rsp_outputs_0;
  logic        rsp_ready;
  logic        cmd_int;
  logic        int_pending;
  logic        int_clear;
  logic        busy;

  tinyml_cmd_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_function_id (req_function_id),
    .req_inputs_0    (req_inputs_0),
    .req_inputs_1    (req_inputs_1),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_timeout     (res_timeout),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_function_id (cmd_function_id),
    .cmd_inputs_0    (cmd_inputs_0),
    .cmd_inputs_1    (cmd_inputs_1),
    .rsp_valid       (rsp_valid),
    .rsp_outputs_0   (rsp_outputs_0),
    .rsp_ready       (rsp_ready),
    .cmd_int         (cmd_int),
    .int_pending     (int_pending),
    .int_clear       (int_clear),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int vectors = 0;
  int miscompares = 0;

  // One transaction: request fields, responder behaviour, and the expected result.
  //   cw    : cycles cmd_ready is held low while cmd_valid is up
  //   same  : response given together with cmd_ready
  //   k     : otherwise, index of the RSP cycle that carries rsp_valid (>= T means too late)
  //   rw    : cycles res_ready is held low once the result is offered
  //   noise : drive stray rsp_valid during the command stall
  typedef struct {
    logic [9:0]  id;
    logic [31:0] in0;
    logic [31:0] in1;
    int          cw;
    bit          same;
    int          k;
    int          rw;
    logic [31:0] rdata;
    bit          noise;
    int          exp_lat;
    logic [31:0] exp_data;
    bit          exp_tmo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: latency in cycles from the accept edge to the first cycle
  // showing res_valid, plus the delivered word and timeout flag.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.same) begin
      r.exp_lat  = 1 + v.cw + 1;
      r.exp_data = v.rdata;
      r.exp_tmo  = 1'b0;
    end else if (v.k < T) begin
      r.exp_lat  = 1 + v.cw + 1 + v.k + 1;
      r.exp_data = v.rdata;
      r.exp_tmo  = 1'b0;
    end else begin
      r.exp_lat  = 1 + v.cw + 1 + T;
      r.exp_data = 32'h0;
      r.exp_tmo  = 1'b1;
    end
    return r;
  endfunction

  task automatic drive_responder(input vec_t v);
    @(negedge clk);
    for (int i = 0; i < v.cw; i++) begin
      check_bit("cmd_valid_stall", cmd_valid, 1'b1);
      check("cmd_function_id_stall", 32'(cmd_function_id), 32'(v.id));
      check("cmd_inputs_0_stall", cmd_inputs_0, v.in0);
      check("cmd_inputs_1_stall", cmd_inputs_1, v.in1);
      rsp_valid     = v.noise;
      rsp_outputs_0 = ~v.rdata;
      @(negedge clk);
    end
    check_bit("cmd_valid_issue", cmd_valid, 1'b1);
    check("cmd_function_id_issue", 32'(cmd_function_id), 32'(v.id));
    cmd_ready     = 1'b1;
    rsp_valid     = v.same;
    rsp_outputs_0 = v.rdata;
    @(negedge clk);
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    if (!v.same) begin
      check_bit("rsp_ready_wait", rsp_ready, 1'b1);
      check_bit("cmd_valid_after_accept", cmd_valid, 1'b0);
      repeat (v.k) @(negedge clk);
      rsp_valid     = 1'b1;
      rsp_outputs_0 = v.rdata;
      @(negedge clk);
      rsp_valid = 1'b0;
    end
  endtask

  task automatic watch_result(input vec_t v);
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!res_valid && cnt < 300);
    check("res_latency", 32'(cnt), 32'(v.exp_lat));
    check("res_data", res_data, v.exp_data);
    check_bit("res_timeout", res_timeout, v.exp_tmo);
    check_bit("busy_done", busy, 1'b1);
  endtask

  task automatic run_txn(input vec_t v);
    int guard = 0;
    req_function_id = v.id;
    req_inputs_0    = v.in0;
    req_inputs_1    = v.in1;
    req_valid       = 1'b1;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL req_accept: req_ready stayed %b for 50 cycles, expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    fork
      drive_responder(v);
      watch_result(v);
    join
    check_bit("rsp_ready_done", rsp_ready, 1'b0);
    check_bit("cmd_valid_done", cmd_valid, 1'b0);
    // Offer a second request while the result is still pending; it must not be taken.
    req_function_id = ~v.id;
    req_valid       = 1'b1;
    for (int i = 0; i < v.rw; i++) begin
      check_bit("res_valid_hold", res_valid, 1'b1);
      check("res_data_hold", res_data, v.exp_data);
      check_bit("res_timeout_hold", res_timeout, v.exp_tmo);
      check_bit("req_ready_done", req_ready, 1'b0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    check_bit("res_valid_handshake", res_valid, 1'b1);
    check_bit("req_ready_handshake", req_ready, 1'b0);
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = 1'b0;
    check_bit("res_valid_after", res_valid, 1'b0);
    check_bit("busy_after", busy, 1'b0);
    check_bit("req_ready_after", req_ready, 1'b1);
    check("cmd_function_id_kept", 32'(cmd_function_id), 32'(v.id));
  endtask

  vec_t dir [7];

  initial begin
    vec_t v;
    int guard;

    rstn = 1'b0;  req_valid = 1'b0;  req_function_id = '0;  req_inputs_0 = '0;
    req_inputs_1 = '0;  res_ready = 1'b0;  cmd_ready = 1'b0;  rsp_valid = 1'b0;
    rsp_outputs_0 = '0;  cmd_int = 1'b0;  int_clear = 1'b0;

    //                id        in0           in1           cw same k   rw rdata         noise lat data          tmo
    dir[0] = '{10'h001, 32'h0000_0005, 32'h0000_0003, 0, 1'b1, 0,  0, 32'h0000_0008, 1'b0, 2,  32'h0000_0008, 1'b0};
    dir[1] = '{10'h02A, 32'h1111_1111, 32'h2222_2222, 5, 1'b0, 2,  1, 32'hCAFE_0001, 1'b1, 10, 32'hCAFE_0001, 1'b0};
    dir[2] = '{10'h003, 32'hAAAA_0000, 32'h0000_BBBB, 0, 1'b0, 10, 0, 32'h1234_5678, 1'b0, 10, 32'h0000_0000, 1'b1};
    dir[3] = '{10'h004, 32'h0000_0010, 32'h0000_0020, 1, 1'b1, 0,  0, 32'h0BAD_F00D, 1'b1, 3,  32'h0BAD_F00D, 1'b0};
    dir[4] = '{10'h005, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0, 0,  4, 32'h55AA_55AA, 1'b0, 3,  32'h55AA_55AA, 1'b0};
    dir[5] = '{10'h006, 32'h0000_0007, 32'h0000_0006, 0, 1'b0, 7,  0, 32'h7777_0007, 1'b0, 10, 32'h7777_0007, 1'b0};
    dir[6] = '{10'h3FF, 32'h0101_0101, 32'h0202_0202, 2, 1'b0, 8,  2, 32'h8888_0008, 1'b1, 12, 32'h0000_0000, 1'b1};

    // Reset values.
    repeat (3) @(negedge clk);
    check_bit("rst_req_ready", req_ready, 1'b0);
    check_bit("rst_cmd_valid", cmd_valid, 1'b0);
    check_bit("rst_rsp_ready", rsp_ready, 1'b0);
    check_bit("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 32'h0);
    check_bit("rst_res_timeout", res_timeout, 1'b0);
    check("rst_cmd_function_id", 32'(cmd_function_id), 32'h0);
    check("rst_cmd_inputs_0", cmd_inputs_0, 32'h0);
    check("rst_cmd_inputs_1", cmd_inputs_1, 32'h0);
    check_bit("rst_int_pending", int_pending, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    check_bit("idle_req_ready", req_ready, 1'b1);
    check_bit("idle_busy", busy, 1'b0);

    // Sticky interrupt and set-over-clear priority.
    cmd_int = 1'b1;
    @(negedge clk);
    cmd_int = 1'b0;
    check_bit("int_set", int_pending, 1'b1);
    @(negedge clk);
    check_bit("int_sticky", int_pending, 1'b1);
    int_clear = 1'b1;
    @(negedge clk);
    check_bit("int_clear", int_pending, 1'b0);
    cmd_int = 1'b1;
    @(negedge clk);
    cmd_int = 1'b0;
    check_bit("int_set_wins", int_pending, 1'b1);
    @(negedge clk);
    int_clear = 1'b0;
    check_bit("int_clear_alone", int_pending, 1'b0);

    // Directed vectors.
    for (int i = 0; i < 7; i++) run_txn(dir[i]);

    // Reset while waiting for a response, then a late response that must be ignored.
    req_function_id = 10'h155;
    req_inputs_0    = 32'hDEAD_0000;
    req_inputs_1    = 32'h0000_BEEF;
    req_valid       = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_bit("mid_rsp_rsp_ready", rsp_ready, 1'b1);
    check_bit("mid_rsp_busy", busy, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_bit("rst_mid_busy", busy, 1'b0);
    check_bit("rst_mid_res_valid", res_valid, 1'b0);
    check_bit("rst_mid_rsp_ready", rsp_ready, 1'b0);
    check_bit("rst_mid_cmd_valid", cmd_valid, 1'b0);
    check("rst_mid_cmd_function_id", 32'(cmd_function_id), 32'h0);
    rsp_valid     = 1'b1;
    rsp_outputs_0 = 32'hDEAD_BEEF;
    @(negedge clk);
    rsp_valid = 1'b0;
    check_bit("late_rsp_res_valid", res_valid, 1'b0);
    check_bit("late_rsp_busy", busy, 1'b0);
    check("late_rsp_res_data", res_data, 32'h0);
    check_bit("late_rsp_req_ready", req_ready, 1'b1);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      v.id    = 10'($urandom);
      v.in0   = $urandom;
      v.in1   = $urandom;
      v.cw    = $urandom_range(0, 4);
      v.same  = ($urandom_range(0, 3) == 0);
      v.k     = $urandom_range(0, T + 2);
      v.rw    = $urandom_range(0, 3);
      v.rdata = $urandom;
      v.noise = 1'($urandom_range(0, 1));
      v = model(v);
      run_txn(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
